// File: rtl/cpu_pkg.sv
// cpu_pkg: RV32I opcode/funct encodings, ALU operation enum and decode helper
// shared by the streaming core and its ALU.
package cpu_pkg;
    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_SYSTEM = 7'b1110011;

    localparam logic [2:0] F3_ADD  = 3'b000;
    localparam logic [2:0] F3_SLL  = 3'b001;
    localparam logic [2:0] F3_SLT  = 3'b010;
    localparam logic [2:0] F3_SLTU = 3'b011;
    localparam logic [2:0] F3_XOR  = 3'b100;
    localparam logic [2:0] F3_SR   = 3'b101;
    localparam logic [2:0] F3_OR   = 3'b110;
    localparam logic [2:0] F3_AND  = 3'b111;
    localparam logic [2:0] F3_W    = 3'b010;

    localparam logic [6:0] F7_BASE = 7'b0000000;
    localparam logic [6:0] F7_ALT  = 7'b0100000;

    localparam logic [31:0] ECALL_INST = 32'h0000_0073;

    typedef enum logic [3:0] {
        ALU_ADD, ALU_SUB, ALU_SLL, ALU_SLT, ALU_SLTU,
        ALU_XOR, ALU_SRL, ALU_SRA, ALU_OR, ALU_AND
    } alu_op_e;

    // alt selects SUB for funct3 000 and SRA for funct3 101
    function automatic alu_op_e alu_from_f3(input logic [2:0] f3, input logic alt);
        case (f3)
            F3_ADD:  return alt ? ALU_SUB : ALU_ADD;
            F3_SLL:  return ALU_SLL;
            F3_SLT:  return ALU_SLT;
            F3_SLTU: return ALU_SLTU;
            F3_XOR:  return ALU_XOR;
            F3_SR:   return alt ? ALU_SRA : ALU_SRL;
            F3_OR:   return ALU_OR;
            default: return ALU_AND;
        endcase
    endfunction
endpackage

// File: rtl/cpu_alu.sv
// cpu_alu: combinational RV32I integer ALU; shifts use the low 5 bits of b.
module cpu_alu
    import cpu_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic [XLEN-1:0] a,
    input  logic [XLEN-1:0] b,
    input  alu_op_e         alu_op,
    output logic [XLEN-1:0] result
);
    always_comb begin
        result = '0;
        case (alu_op)
            ALU_ADD:  result = a + b;
            ALU_SUB:  result = a - b;
            ALU_SLL:  result = a << b[4:0];
            ALU_SLT:  result = XLEN'($signed(a) < $signed(b));
            ALU_SLTU: result = XLEN'(a < b);
            ALU_XOR:  result = a ^ b;
            ALU_SRL:  result = a >> b[4:0];
            ALU_SRA:  result = $signed(a) >>> b[4:0];
            ALU_OR:   result = a | b;
            ALU_AND:  result = a & b;
            default:  result = '0;
        endcase
    end
endmodule

// File: rtl/cpu.sv
// cpu: single-cycle RV32I core executing a pre-ordered instruction stream;
// control flow never redirects, so the PC only feeds AUIPC/JAL/JALR results.
module cpu
    import cpu_pkg::*;
#(
    parameter int          XLEN       = 32,
    parameter int          DMEM_WORDS = 64,
    parameter logic [31:0] PC_RESET   = 32'h0000_0000
) (
    input  logic            i_clk,
    input  logic            i_rst_n,
    input  logic            i_start,
    input  logic [31:0]     i_inst,
    output logic            o_ecall_ready,
    output logic [XLEN-1:0] o_ecall_data
);
    localparam int AW = $clog2(DMEM_WORDS);

    logic [XLEN-1:0] regs_q [32];
    logic [XLEN-1:0] dmem_q [DMEM_WORDS];
    logic [XLEN-1:0] pc_q, pc_d;
    logic            ecall_ready_q, ecall_ready_d;
    logic [XLEN-1:0] ecall_data_q, ecall_data_d;

    logic [6:0]      opcode, f7;
    logic [4:0]      rd, rs1, rs2;
    logic [2:0]      f3;
    logic [XLEN-1:0] imm_i, imm_s, imm_u, rs1_v, rs2_v;
    logic [XLEN-1:0] alu_a, alu_b, alu_res, wb_data;
    alu_op_e         alu_op;
    logic            wb_en, is_load, is_store, is_ecall;
    logic [AW-1:0]   idx;

    assign opcode   = i_inst[6:0];
    assign rd       = i_inst[11:7];
    assign f3       = i_inst[14:12];
    assign rs1      = i_inst[19:15];
    assign rs2      = i_inst[24:20];
    assign f7       = i_inst[31:25];
    assign imm_i    = {{(XLEN-12){i_inst[31]}}, i_inst[31:20]};
    assign imm_s    = {{(XLEN-12){i_inst[31]}}, i_inst[31:25], i_inst[11:7]};
    assign imm_u    = {i_inst[31:12], 12'b0};
    assign rs1_v    = rs1 == 5'd0 ? '0 : regs_q[rs1];
    assign rs2_v    = rs2 == 5'd0 ? '0 : regs_q[rs2];
    assign is_ecall = i_inst == ECALL_INST;

    always_comb begin
        alu_a    = rs1_v;
        alu_b    = imm_i;
        alu_op   = ALU_ADD;
        wb_en    = 1'b0;
        is_load  = 1'b0;
        is_store = 1'b0;
        case (opcode)
            OPC_OP: begin
                alu_b  = rs2_v;
                alu_op = alu_from_f3(f3, f7[5]);
                wb_en  = f7 == F7_BASE || (f7 == F7_ALT && (f3 == F3_ADD || f3 == F3_SR));
            end
            OPC_OP_IMM: begin
                alu_op = alu_from_f3(f3, f3 == F3_SR && f7[5]);
                wb_en  = f3 == F3_SLL ? f7 == F7_BASE :
                         f3 == F3_SR  ? (f7 == F7_BASE || f7 == F7_ALT) : 1'b1;
            end
            OPC_LUI: begin
                alu_a = '0;
                alu_b = imm_u;
                wb_en = 1'b1;
            end
            OPC_AUIPC: begin
                alu_a = pc_q;
                alu_b = imm_u;
                wb_en = 1'b1;
            end
            OPC_JAL: begin
                alu_a = pc_q;
                alu_b = XLEN'(4);
                wb_en = 1'b1;
            end
            OPC_JALR: begin
                alu_a = pc_q;
                alu_b = XLEN'(4);
                wb_en = f3 == F3_ADD;
            end
            OPC_LOAD: begin
                is_load = f3 == F3_W;
                wb_en   = f3 == F3_W;
            end
            OPC_STORE: begin
                alu_b    = imm_s;
                is_store = f3 == F3_W;
            end
            default: ;
        endcase
    end

    cpu_alu #(.XLEN(XLEN)) u_alu (
        .a      (alu_a),
        .b      (alu_b),
        .alu_op (alu_op),
        .result (alu_res)
    );

    // memory address comes from the ALU sum; it wraps naturally modulo DMEM_WORDS
    assign idx           = alu_res[AW+1:2];
    assign wb_data       = is_load ? dmem_q[idx] : alu_res;
    assign pc_d          = pc_q + XLEN'(4);
    assign ecall_ready_d = i_start && is_ecall;
    assign ecall_data_d  = is_ecall ? regs_q[10] : ecall_data_q;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            for (int i = 0; i < 32; i++) regs_q[i] <= '0;
            for (int i = 0; i < DMEM_WORDS; i++) dmem_q[i] <= '0;
            pc_q          <= PC_RESET;
            ecall_ready_q <= 1'b0;
            ecall_data_q  <= '0;
        end else begin
            ecall_ready_q <= ecall_ready_d;
            if (i_start) begin
                pc_q         <= pc_d;
                ecall_data_q <= ecall_data_d;
                if (wb_en && rd != 5'd0) regs_q[rd] <= wb_data;
                if (is_store) dmem_q[idx] <= rs2_v;
            end
        end
    end

    assign o_ecall_ready = ecall_ready_q;
    assign o_ecall_data  = ecall_data_q;
endmodule

// File: tb/tb_cpu.sv
// tb_cpu: directed self-checking bench for the streaming RV32I core; registers are
// observed by moving them into x10 and issuing ECALL.
module tb_cpu;
    logic        i_clk = 1'b0;
    logic        i_rst_n = 1'b0;
    logic        i_start = 1'b0;
    logic [31:0] i_inst = 32'h0;
    logic        o_ecall_ready;
    logic [31:0] o_ecall_data;
    int          checks = 0;
    int          errors = 0;
    logic [31:0] pc_model = 32'h0;

    localparam logic [31:0] NOP   = 32'h0000_0000;
    localparam logic [31:0] ECALL = 32'h0000_0073;

    cpu dut (
        .i_clk         (i_clk),
        .i_rst_n       (i_rst_n),
        .i_start       (i_start),
        .i_inst        (i_inst),
        .o_ecall_ready (o_ecall_ready),
        .o_ecall_data  (o_ecall_data)
    );

    always #5 i_clk = ~i_clk;

    task automatic exec(input logic [31:0] inst);
        i_inst = inst;
        @(posedge i_clk);
        #1;
        if (i_start) pc_model += 32'd4;
    endtask

    task automatic test_reset;
        i_rst_n = 1'b0;
        #2;
        checks++;
        if (o_ecall_ready !== 1'b0 || o_ecall_data !== 32'h0) begin
            errors++;
            $display("FAIL reset_outputs: ready=%b data=%h required ready=0 data=0", o_ecall_ready, o_ecall_data);
        end
        @(posedge i_clk);
        #1;
        i_rst_n = 1'b1;
        // ECALL presented while idle must not execute
        i_start = 1'b0;
        for (int i = 0; i < 3; i++) begin
            exec(ECALL);
            checks++;
            if (o_ecall_ready !== 1'b0) begin
                errors++;
                $display("FAIL idle_no_ecall: ready=%b required 0", o_ecall_ready);
            end
        end
    endtask

    task automatic test_nop_pc;
        i_start = 1'b1;
        for (int i = 0; i < 5; i++) begin
            exec(NOP);
            checks++;
            if (o_ecall_ready !== 1'b0) begin
                errors++;
                $display("FAIL nop_ready: cycle %0d ready=%b required 0", i, o_ecall_ready);
            end
        end
        exec(32'h0000_0517);
        exec(ECALL);
        checks++;
        if (o_ecall_ready !== 1'b1 || o_ecall_data !== 32'd20) begin
            errors++;
            $display("FAIL pc_after_nops: ready=%b data=%h required ready=1 data=00000014", o_ecall_ready, o_ecall_data);
        end
        exec(NOP);
    endtask

    task automatic test_ecall_pulse;
        exec(32'h0050_0513);
        checks++;
        if (o_ecall_ready !== 1'b0) begin
            errors++;
            $display("FAIL pre_ecall_ready: ready=%b required 0", o_ecall_ready);
        end
        exec(ECALL);
        checks++;
        if (o_ecall_ready !== 1'b1 || o_ecall_data !== 32'd5) begin
            errors++;
            $display("FAIL ecall_a0: ready=%b data=%h required ready=1 data=00000005", o_ecall_ready, o_ecall_data);
        end
        exec(NOP);
        checks++;
        if (o_ecall_ready !== 1'b0 || o_ecall_data !== 32'd5) begin
            errors++;
            $display("FAIL ecall_pulse_end: ready=%b data=%h required ready=0 data=00000005", o_ecall_ready, o_ecall_data);
        end
    endtask

    task automatic test_shifts;
        logic [31:0] movs [5];
        logic [31:0] exps [5];
        movs = '{32'h0001_0533, 32'h0001_8533, 32'h0002_0533, 32'h0000_A533, 32'h4010_0533};
        exps = '{32'h0FFF_FFFF, 32'hFFFF_FFFF, 32'h1, 32'h1, 32'h1};
        exec(32'hFFF0_0093);
        exec(32'h0040_D113);
        exec(32'h4040_D193);
        exec(32'h0010_3233);
        for (int i = 0; i < 5; i++) begin
            exec(movs[i]);
            exec(ECALL);
            checks++;
            if (o_ecall_data !== exps[i]) begin
                errors++;
                $display("FAIL alu_result_%0d: data=%h required %h", i, o_ecall_data, exps[i]);
            end
        end
    endtask

    task automatic test_mem;
        logic [31:0] loads [3];
        loads = '{32'h0080_2503, 32'h1080_2503, 32'h00B0_2503};
        exec(32'h1234_52B7);
        exec(32'h6782_8293);
        exec(32'h0050_2423);
        for (int i = 0; i < 3; i++) begin
            exec(32'h0000_0513);
            exec(loads[i]);
            exec(ECALL);
            checks++;
            if (o_ecall_data !== 32'h1234_5678) begin
                errors++;
                $display("FAIL load_word_%0d: data=%h required 12345678", i, o_ecall_data);
            end
        end
    endtask

    task automatic test_x0_jal;
        logic [31:0] jal_pc;
        exec(32'h0070_0013);
        exec(32'h0000_0533);
        exec(ECALL);
        checks++;
        if (o_ecall_data !== 32'h0) begin
            errors++;
            $display("FAIL x0_write_ignored: data=%h required 00000000", o_ecall_data);
        end
        jal_pc = pc_model;
        exec(32'h0000_056F);
        exec(ECALL);
        checks++;
        if (o_ecall_data !== jal_pc + 32'd4) begin
            errors++;
            $display("FAIL jal_link: data=%h required %h", o_ecall_data, jal_pc + 32'd4);
        end
    endtask

    task automatic test_back_to_back;
        exec(32'h0090_0513);
        exec(ECALL);
        checks++;
        if (o_ecall_ready !== 1'b1 || o_ecall_data !== 32'd9) begin
            errors++;
            $display("FAIL b2b_first: ready=%b data=%h required ready=1 data=00000009", o_ecall_ready, o_ecall_data);
        end
        exec(ECALL);
        checks++;
        if (o_ecall_ready !== 1'b1 || o_ecall_data !== 32'd9) begin
            errors++;
            $display("FAIL b2b_second: ready=%b data=%h required ready=1 data=00000009", o_ecall_ready, o_ecall_data);
        end
        i_inst = ECALL;
        #2;
        i_rst_n = 1'b0;
        #1;
        checks++;
        if (o_ecall_ready !== 1'b0 || o_ecall_data !== 32'h0) begin
            errors++;
            $display("FAIL async_reset: ready=%b data=%h required ready=0 data=0", o_ecall_ready, o_ecall_data);
        end
        @(posedge i_clk);
        #1;
        i_rst_n = 1'b1;
        pc_model = 32'h0;
        exec(ECALL);
        checks++;
        if (o_ecall_ready !== 1'b1 || o_ecall_data !== 32'h0) begin
            errors++;
            $display("FAIL a0_cleared: ready=%b data=%h required ready=1 data=0", o_ecall_ready, o_ecall_data);
        end
        exec(32'h0000_0517);
        exec(ECALL);
        checks++;
        if (o_ecall_data !== 32'd4) begin
            errors++;
            $display("FAIL pc_cleared: data=%h required 00000004", o_ecall_data);
        end
    endtask

    initial begin
        test_reset();
        test_nop_pc();
        test_ecall_pulse();
        test_shifts();
        test_mem();
        test_x0_jal();
        test_back_to_back();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
